ascon_sbox_layer_seq: RTL and testbench

- Sequences the ASCON substitution layer over a full 320-bit permutation state (five 64-bit words x0..x4).
- Feeds columns through LANES instances of the existing 5-bit S-box core (module ASCON), writing results back in place.
- Sits between the round-constant-addition stage and the linear-diffusion stage of the permutation datapath.
- Valid/ready handshakes on both sides; area and throughput are traded through LANES.

---
 rtl/ascon_sbox_layer_seq_pkg.sv | 37 +++
 rtl/ascon_sbox_core.sv | 20 ++
 rtl/ascon_sbox_lanes.sv | 16 +
 rtl/ascon_sbox_layer_seq.sv | 108 ++++++++++
 tb/tb_ascon_sbox_layer_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_sbox_layer_seq_pkg.sv
// ascon_pkg: shared widths, sequencer state enum and column pack/unpack helpers
// for the ASCON substitution-layer sequencer.
//   ASCON_STATE_W - full permutation state width (5 words x 64 bits)
//   ASCON_WORD_W  - width of one state word x0..x4
//   ASCON_SBOX_W  - width of one S-box column
//   pack_column   - gathers bit i of x0..x4 into {x0,x1,x2,x3,x4}
//   unpack_column - scatters a 5-bit column back to bit i of x0..x4
package ascon_pkg;
   localparam int ASCON_STATE_W = 320;
   localparam int ASCON_WORD_W  = 64;
   localparam int ASCON_SBOX_W  = 5;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   function automatic logic [ASCON_SBOX_W-1:0] pack_column(
      input logic [ASCON_STATE_W-1:0] s,
      input int                       i
   );
      return {s[4*ASCON_WORD_W+i], s[3*ASCON_WORD_W+i], s[2*ASCON_WORD_W+i],
              s[ASCON_WORD_W+i], s[i]};
   endfunction

   function automatic logic [ASCON_STATE_W-1:0] unpack_column(
      input logic [ASCON_STATE_W-1:0] s,
      input int                       i,
      input logic [ASCON_SBOX_W-1:0]  c
   );
      logic [ASCON_STATE_W-1:0] r;
      r = s;
      r[4*ASCON_WORD_W+i] = c[4];
      r[3*ASCON_WORD_W+i] = c[3];
      r[2*ASCON_WORD_W+i] = c[2];
      r[ASCON_WORD_W+i]   = c[1];
      r[i]                = c[0];
      return r;
   endfunction
endpackage

// File: rtl/ascon_sbox_core.sv
// ASCON: 5-bit ASCON S-box core, bitsliced form.
//   i_x - column input  {x0,x1,x2,x3,x4}
//   o_y - column output {x0,x1,x2,x3,x4}
module ASCON (
   input  logic [4:0] i_x,
   output logic [4:0] o_y
);
   // w_a/w_b are indexed by word number: [0] = x0 ... [4] = x4
   logic [4:0] w_a, w_b;
   always_comb begin
      w_a[0] = i_x[4] ^ i_x[0];
      w_a[1] = i_x[3];
      w_a[2] = i_x[2] ^ i_x[3];
      w_a[3] = i_x[1];
      w_a[4] = i_x[0] ^ i_x[1];
      for (int k = 0; k < 5; k++)
         w_b[k] = w_a[k] ^ (~w_a[(k+1)%5] & w_a[(k+2)%5]);
   end
   assign o_y = {w_b[0] ^ w_b[4], w_b[1] ^ w_b[0], ~w_b[2], w_b[3] ^ w_b[2], w_b[4]};
endmodule

// File: rtl/ascon_sbox_lanes.sv
// ascon_sbox_lanes: LANES parallel ASCON S-box cores over a packed column slice.
//   i_cols - LANES columns, lane l at [5*l +: 5]
//   o_cols - substituted columns, same packing
module ascon_sbox_lanes import ascon_pkg::*; #(
   parameter int LANES = 4
) (
   input  logic [ASCON_SBOX_W*LANES-1:0] i_cols,
   output logic [ASCON_SBOX_W*LANES-1:0] o_cols
);
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      ASCON u_sbox (
         .i_x(i_cols[ASCON_SBOX_W*l +: ASCON_SBOX_W]),
         .o_y(o_cols[ASCON_SBOX_W*l +: ASCON_SBOX_W])
      );
   end
endmodule

// File: rtl/ascon_sbox_layer_seq.sv
// ascon_sbox_layer_seq: applies the ASCON S-box layer to a 320-bit state,
// LANES columns per cycle, with valid/ready on both sides.
//   clk, rst              - clock, async active-high reset
//   in_valid/in_ready     - input handshake, in_state = {x0,x1,x2,x3,x4}
//   flush                 - synchronous abort to IDLE, state register kept
//   out_valid/out_ready   - output handshake, out_state same packing
//   busy                  - high while RUN or DONE
//   layer_cnt             - completed layers, only with ASCON_SBOX_SEQ_CNT_EN
module ascon_sbox_layer_seq import ascon_pkg::*; #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ASCON_STATE_W-1:0] in_state,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ASCON_STATE_W-1:0] out_state,
   output logic                     busy
`ifdef ASCON_SBOX_SEQ_CNT_EN
   ,
   output logic [CNT_W-1:0]         layer_cnt
`endif
);
   localparam int N     = ASCON_WORD_W / LANES;
   localparam int COL_W = N > 1 ? $clog2(N) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
         LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
      $error("ascon_sbox_layer_seq: LANES must be a power of two in 1..64");
   end

   seq_state_t                 r_state, w_nstate;
   logic [ASCON_STATE_W-1:0]   r_data, w_sub;
   logic [COL_W-1:0]           r_col;
   logic [ASCON_SBOX_W*LANES-1:0] w_lane_in, w_lane_out;
   logic                       w_last;
   int                         w_base;

   assign w_last = r_col == COL_W'(N-1);
   assign w_base = int'(r_col) * LANES;

   always_comb begin
      w_lane_in = '0;
      for (int j = 0; j < LANES; j++)
         w_lane_in[ASCON_SBOX_W*j +: ASCON_SBOX_W] = pack_column(r_data, w_base + j);
   end

   ascon_sbox_lanes #(.LANES(LANES)) u_lanes (
      .i_cols(w_lane_in),
      .o_cols(w_lane_out)
   );

   always_comb begin
      w_sub = r_data;
      for (int j = 0; j < LANES; j++)
         w_sub = unpack_column(w_sub, w_base + j, w_lane_out[ASCON_SBOX_W*j +: ASCON_SBOX_W]);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_nstate;

   always_comb begin
      w_nstate  = r_state;
      in_ready  = r_state == IDLE;
      out_valid = r_state == DONE;
      busy      = r_state != IDLE;
      if (flush)                            w_nstate = IDLE;
      else if (r_state == IDLE && in_valid)  w_nstate = RUN;
      else if (r_state == RUN && w_last)     w_nstate = DONE;
      else if (r_state == DONE && out_ready) w_nstate = IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_data <= '0;
         r_col  <= '0;
      end else if (flush) begin
         r_col  <= '0;
      end else if (r_state == IDLE && in_valid) begin
         r_data <= in_state;
         r_col  <= '0;
      end else if (r_state == RUN) begin
         r_data <= w_sub;
         r_col  <= w_last ? '0 : r_col + COL_W'(1);
      end

   assign out_state = r_data;

`ifdef ASCON_SBOX_SEQ_CNT_EN
   if (CNT_W < 1) begin : g_bad_cnt
      $error("ascon_sbox_layer_seq: CNT_W must be at least 1");
   end
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst)                                  r_cnt <= '0;
      else if (!flush && out_valid && out_ready) r_cnt <= r_cnt + CNT_W'(1);
   assign layer_cnt = r_cnt;
`else
   if (CNT_W < 1) begin : g_bad_cnt
      $error("ascon_sbox_layer_seq: CNT_W must be at least 1");
   end
`endif
endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// tb_ascon_sbox_layer_seq: self-checking bench for the S-box layer sequencer,
// three instances (LANES 4, 1, 64) sharing one stimulus stream.
module tb_ascon_sbox_layer_seq;
   logic         clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 1;
   logic [319:0] in_state = '0;
   logic         in_ready4, out_valid4, busy4, in_ready1, out_valid1, busy1;
   logic         in_ready64, out_valid64, busy64;
   logic [319:0] out_state4, out_state1, out_state64;
`ifdef ASCON_SBOX_SEQ_CNT_EN
   logic [15:0]  layer_cnt4, layer_cnt1, layer_cnt64;
   int           hs4 = 0;
`endif

   always #5 clk = ~clk;

   ascon_sbox_layer_seq #(.LANES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_state(in_state),
      .flush(flush), .out_valid(out_valid4), .out_ready(out_ready), .out_state(out_state4),
      .busy(busy4)
`ifdef ASCON_SBOX_SEQ_CNT_EN
      , .layer_cnt(layer_cnt4)
`endif
   );
   ascon_sbox_layer_seq #(.LANES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_state(in_state),
      .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_state(out_state1),
      .busy(busy1)
`ifdef ASCON_SBOX_SEQ_CNT_EN
      , .layer_cnt(layer_cnt1)
`endif
   );
   ascon_sbox_layer_seq #(.LANES(64)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_state(in_state),
      .flush(flush), .out_valid(out_valid64), .out_ready(out_ready), .out_state(out_state64),
      .busy(busy64)
`ifdef ASCON_SBOX_SEQ_CNT_EN
      , .layer_cnt(layer_cnt64)
`endif
   );

   typedef struct {
      logic [319:0] st;
      logic [319:0] exp;
   } vec_t;

   int           checks = 0, errors = 0;
   logic [319:0] q4[$], q1[$], q64[$];
   logic [4:0]   sb_tab [32];
   vec_t         vecs [5];

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int w = 0; w < 10; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   // golden model: table S-box applied to the first ncols columns
   function automatic logic [319:0] sub_model(input logic [319:0] s, input int ncols);
      logic [319:0] r;
      logic [4:0]   v, o;
      r = s;
      for (int i = 0; i < ncols; i++) begin
         v = {s[256+i], s[192+i], s[128+i], s[64+i], s[i]};
         o = sb_tab[v];
         {r[256+i], r[192+i], r[128+i], r[64+i], r[i]} = o;
      end
      return r;
   endfunction

   // scoreboard: an output handshake happens at the next edge when valid & ready here
   always @(negedge clk) begin
      if (!rst && !flush && out_ready) begin
         if (out_valid4) begin
            if (q4.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut4 unexpected output %h", out_state4);
            end else chk("dut4 out_state", out_state4, q4.pop_front());
`ifdef ASCON_SBOX_SEQ_CNT_EN
            hs4++;
`endif
         end
         if (out_valid1) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut1 unexpected output %h", out_state1);
            end else chk("dut1 out_state", out_state1, q1.pop_front());
         end
         if (out_valid64) begin
            if (q64.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut64 unexpected output %h", out_state64);
            end else chk("dut64 out_state", out_state64, q64.pop_front());
         end
      end
   end

   task automatic run_vec(input logic [319:0] st, input logic [319:0] exp);
      int l4 = -1, l1 = -1, l64 = -1;
      chk("in_ready before accept", in_ready4, 1);
      in_state = st;
      in_valid = 1;
      q4.push_back(exp); q1.push_back(exp); q64.push_back(exp);
      step();
      in_valid = 0;
      in_state = rnd320();
      for (int k = 1; k <= 70; k++) begin
         step();
         if (out_valid4 && l4 < 0) l4 = k;
         if (out_valid1 && l1 < 0) l1 = k;
         if (out_valid64 && l64 < 0) l64 = k;
      end
      chk("latency lanes4", l4, 16);
      chk("latency lanes1", l1, 64);
      chk("latency lanes64", l64, 1);
   endtask

   initial begin
      logic [319:0] st, partial, junk;
      int seen;
      sb_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
      vecs[0].st  = '0;
      vecs[0].exp = {128'h0, {64{1'b1}}, 128'h0};
      for (int i = 1; i < 5; i++) begin
         vecs[i].st  = rnd320();
         vecs[i].exp = sub_model(vecs[i].st, 64);
      end

      rst = 1;
      repeat (2) step();
      chk("reset in_ready", in_ready4, 1);
      chk("reset out_valid", out_valid4, 0);
      chk("reset busy", busy4, 0);
      chk("reset out_state", out_state4, '0);
`ifdef ASCON_SBOX_SEQ_CNT_EN
      chk("reset layer_cnt", layer_cnt4, 0);
`endif
      rst = 0;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i].st, vecs[i].exp);

      // backpressure in DONE: output held, input pulses ignored
      out_ready = 0;
      in_state = vecs[1].st;
      in_valid = 1;
      q4.push_back(vecs[1].exp); q1.push_back(vecs[1].exp); q64.push_back(vecs[1].exp);
      step();
      in_valid = 0;
      repeat (70) step();
      for (int c = 0; c < 10; c++) begin
         in_valid = c[0];
         in_state = rnd320();
         step();
         chk("hold out_valid", out_valid4, 1);
         chk("hold out_state", out_state4, vecs[1].exp);
         chk("hold in_ready", in_ready4, 0);
      end
      in_valid = 0;
      out_ready = 1;
      step();
      chk("release out_valid", out_valid4, 0);
      chk("release in_ready", in_ready4, 1);
      step();

      // flush while RUN with col = 7
      out_ready = 0;
      st = vecs[2].st;
      in_state = st;
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (7) step();
      flush = 1;
      step();
      flush = 0;
      partial = sub_model(st, 28);
      chk("flush in_ready", in_ready4, 1);
      chk("flush busy", busy4, 0);
      chk("flush keeps state lanes4", out_state4, partial);
      chk("flush keeps state lanes1", out_state1, sub_model(st, 7));
      chk("flush lanes64 in_ready", in_ready64, 1);
      out_ready = 1;
      seen = 0;
      repeat (20) begin
         step();
         if (out_valid4 || out_valid1 || out_valid64) seen = 1;
      end
      chk("no output after flush", seen, 0);
      // flush wins over an accept in IDLE
      flush = 1;
      in_valid = 1;
      in_state = vecs[3].st;
      step();
      flush = 0;
      in_valid = 0;
      chk("flush priority busy", busy4, 0);
      chk("flush priority no load", out_state4, partial);
      run_vec(vecs[3].st, vecs[3].exp);

      // asynchronous reset mid-RUN
      in_state = vecs[4].st;
      in_valid = 1;
      q64.push_back(vecs[4].exp);
      step();
      in_valid = 0;
      repeat (5) step();
      #2;
      rst = 1;
      #1;
      chk("async rst out_valid", out_valid4, 0);
      chk("async rst in_ready", in_ready4, 1);
      chk("async rst busy", busy4, 0);
      chk("async rst out_state", out_state4, '0);
      chk("async rst lanes1 busy", busy1, 0);
`ifdef ASCON_SBOX_SEQ_CNT_EN
      chk("async rst layer_cnt", layer_cnt4, 0);
      hs4 = 0;
`endif
      step();
      rst = 0;
      step();
      junk = rnd320();
      run_vec(junk, sub_model(junk, 64));
      run_vec(vecs[4].st, vecs[4].exp);
`ifdef ASCON_SBOX_SEQ_CNT_EN
      chk("layer_cnt after handshakes", layer_cnt4, hs4);
`endif

      chk("q4 drained", q4.size(), 0);
      chk("q1 drained", q1.size(), 0);
      chk("q64 drained", q64.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
